orb_wr_sched: RTL and testbench

Write-side scheduler for the orbit frame double buffer (2 banks × 2048 × 12-bit words). Several producers (fast channel, slow channels, housekeeping) request word writes. The block arbitrates them round-robin and steers every write into the bank the orbit serializer is not currently reading. It also tracks the bank swap signalled by the serializer's switch output and reports how completely each bank was filled before it went on air.

---
 rtl/orb_pkg.sv | 13 +
 rtl/orb_wr_sched_rr_arbiter.sv | 36 +++
 rtl/orb_wr_sched.sv | 127 ++++++++++++
 tb/tb_orb_wr_sched.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/orb_pkg.sv
// Shared constants and FSM encoding for the orbit frame double-buffer write path.
package orb_pkg;

  localparam int ORB_AW         = 11;
  localparam int ORB_DW         = 12;
  localparam int ORB_BANK_WORDS = 2048;

  typedef enum logic {
    S_IDLE,
    S_WR
  } state_t;

endpackage

// File: rtl/orb_wr_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int  NREQ = 3,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   index,
  output logic            any
);

  int            slot;
  logic [PW-1:0] cand;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    gnt   = '0;
    index = '0;
    any   = 1'b0;
    slot  = 0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      slot = int'(ptr) + k;
      if (slot >= NREQ) slot = slot - NREQ;
      cand = PW'(slot);
      if (!any && req[cand]) begin
        any       = 1'b1;
        index     = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/orb_wr_sched.sv
// Round-robin write scheduler for the orbit double buffer: steers writes into the bank
// the serializer is not reading and reports per-bank fill at every bank swap.
module orb_wr_sched
  import orb_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int AW         = ORB_AW,
  parameter int DW         = ORB_DW,
  parameter int BANK_WORDS = ORB_BANK_WORDS
) (
  input  logic              iClkOrb,
  input  logic              reset,
  input  logic              iSwitch,
  input  logic [NREQ-1:0]   iReq,
  input  logic [NREQ*AW-1:0] iAddr,
  input  logic [NREQ*DW-1:0] iData,
  output logic [NREQ-1:0]   oGnt,
  output logic              oWrEn,
  output logic [AW:0]       oWrAddr,
  output logic [DW-1:0]     oWrData,
  output logic              oSwap,
  output logic              oShort,
  output logic [AW:0]       oFill,
  output logic              oBusy
);

  localparam int            PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW:0]   FULL = (AW+1)'(BANK_WORDS);
  localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

  state_t          state, state_n;
  logic            sw_dly, sw_pend, sw_pend_n;
  logic [PW-1:0]   ptr, ptr_n;

  logic [NREQ-1:0] arb_gnt;
  logic [PW-1:0]   arb_idx;
  logic            arb_any;

  logic [NREQ-1:0] gnt_n;
  logic            wr_en_n, swap_n, short_n, busy_n;
  logic [AW:0]     wr_addr_n, fill_n;
  logic [DW-1:0]   wr_data_n;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (iReq),
    .ptr   (ptr),
    .gnt   (arb_gnt),
    .index (arb_idx),
    .any   (arb_any)
  );

  // Write-port outputs are loaded on the edge entering S_WR and cleared on the edge
  // leaving it, so they are valid exactly for the S_WR cycle.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    sw_pend_n = sw_pend;
    fill_n    = oFill;
    gnt_n     = '0;
    wr_en_n   = 1'b0;
    wr_addr_n = '0;
    wr_data_n = '0;
    swap_n    = 1'b0;
    short_n   = 1'b0;
    busy_n    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (sw_pend) begin
          swap_n    = 1'b1;
          short_n   = (oFill != FULL);
          fill_n    = '0;
          sw_pend_n = 1'b0;
        end else if (arb_any) begin
          state_n   = S_WR;
          gnt_n     = arb_gnt;
          wr_en_n   = 1'b1;
          busy_n    = 1'b1;
          wr_addr_n = {~iSwitch, iAddr[int'(arb_idx)*AW +: AW]};
          wr_data_n = iData[int'(arb_idx)*DW +: DW];
          ptr_n     = (arb_idx == LAST) ? '0 : arb_idx + 1'b1;
        end
      end
      S_WR: begin
        state_n = S_IDLE;
        fill_n  = (oFill >= FULL) ? FULL : oFill + 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    // A new serializer edge outranks clearing a swap processed in the same cycle.
    if (iSwitch != sw_dly) sw_pend_n = 1'b1;
  end

  always_ff @(posedge iClkOrb or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      sw_dly  <= 1'b0;
      sw_pend <= 1'b0;
      ptr     <= '0;
      oGnt    <= '0;
      oWrEn   <= 1'b0;
      oWrAddr <= '0;
      oWrData <= '0;
      oSwap   <= 1'b0;
      oShort  <= 1'b0;
      oFill   <= '0;
      oBusy   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample its pre-edge
      // inputs, independent of statement order within the block.
      state   <= state_n;
      sw_dly  <= iSwitch;
      sw_pend <= sw_pend_n;
      ptr     <= ptr_n;
      oGnt    <= gnt_n;
      oWrEn   <= wr_en_n;
      oWrAddr <= wr_addr_n;
      oWrData <= wr_data_n;
      oSwap   <= swap_n;
      oShort  <= short_n;
      oFill   <= fill_n;
      oBusy   <= busy_n;
    end
  end

endmodule

// File: tb/tb_orb_wr_sched.sv
// Directed and randomized bench for orb_wr_sched against a transaction-level model of
// the scheduling rules (round-robin pick, bank steering, swap/fill bookkeeping).
module tb_orb_wr_sched;

  localparam int NREQ = 3;
  localparam int AW   = 11;
  localparam int DW   = 12;
  localparam int BW   = 2048;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               sw = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*AW-1:0] addr = '0;
  logic [NREQ*DW-1:0] data = '0;

  logic [NREQ-1:0]    o_gnt;
  logic               o_wr_en;
  logic [AW:0]        o_wr_addr;
  logic [DW-1:0]      o_wr_data;
  logic               o_swap;
  logic               o_short;
  logic [AW:0]        o_fill;
  logic               o_busy;

  orb_wr_sched dut (
    .iClkOrb (clk),
    .reset   (reset),
    .iSwitch (sw),
    .iReq    (req),
    .iAddr   (addr),
    .iData   (data),
    .oGnt    (o_gnt),
    .oWrEn   (o_wr_en),
    .oWrAddr (o_wr_addr),
    .oWrData (o_wr_data),
    .oSwap   (o_swap),
    .oShort  (o_short),
    .oFill   (o_fill),
    .oBusy   (o_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int left [NREQ];

  // Reference model state and expected outputs for the coming cycle.
  int              m_ptr, m_fill;
  bit              m_inwr, m_pend, m_swdly;
  logic [NREQ-1:0] e_gnt;
  logic            e_wren, e_swap, e_short, e_busy;
  logic [AW:0]     e_addr;
  logic [DW-1:0]   e_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] g);
    for (int b = 0; b < NREQ; b++) if (((g >> b) & 3'b1) != 0) return b;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_fill = 0; m_inwr = 0; m_pend = 0; m_swdly = 0;
    e_gnt = '0; e_wren = 0; e_swap = 0; e_short = 0; e_busy = 0;
    e_addr = '0; e_data = '0;
  endtask

  // One clock edge of the scheduling rules, using the inputs as they stand before it.
  task automatic model_step();
    bit sw_edge;
    int w;
    sw_edge = (sw !== m_swdly);
    m_swdly = sw;
    e_gnt = '0; e_wren = 0; e_swap = 0; e_short = 0; e_busy = 0;
    e_addr = '0; e_data = '0;
    if (m_inwr) begin
      m_inwr = 0;
      if (m_fill < BW) m_fill++;
    end else if (m_pend) begin
      m_pend  = 0;
      e_swap  = 1;
      e_short = (m_fill != BW);
      m_fill  = 0;
    end else if (req != 0) begin
      w = -1;
      for (int off = 0; off < NREQ; off++)
        if (w < 0 && ((req >> ((m_ptr + off) % NREQ)) & 3'b1) != 0) w = (m_ptr + off) % NREQ;
      e_gnt  = 3'(1) << w;
      e_wren = 1;
      e_busy = 1;
      e_addr = {~sw, AW'(addr >> (w * AW))};
      e_data = DW'(data >> (w * DW));
      m_ptr  = (w + 1) % NREQ;
      m_inwr = 1;
    end
    if (sw_edge) m_pend = 1;
  endtask

  task automatic new_word(input int r);
    addr[r*AW +: AW] = AW'($urandom);
    data[r*DW +: DW] = DW'($urandom);
  endtask

  task automatic request(input int r, input int n);
    left[r] = n;
    req |= 3'(1) << r;
    new_word(r);
  endtask

  task automatic clear_requests();
    req = '0;
    for (int r = 0; r < NREQ; r++) left[r] = 0;
  endtask

  // Requesters react to the grant they see: next word, or drop the request when done.
  task automatic service();
    for (int r = 0; r < NREQ; r++) begin
      if (((e_gnt >> r) & 3'b1) != 0) begin
        if (left[r] > 0) left[r]--;
        if (left[r] == 0) req &= ~(3'(1) << r);
        else new_word(r);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cycle++;
    chk("gnt",     32'(o_gnt),     32'(e_gnt));
    chk("wr_en",   32'(o_wr_en),   32'(e_wren));
    chk("wr_addr", 32'(o_wr_addr), 32'(e_addr));
    chk("wr_data", 32'(o_wr_data), 32'(e_data));
    chk("swap",    32'(o_swap),    32'(e_swap));
    chk("short",   32'(o_short),   32'(e_short));
    chk("fill",    32'(o_fill),    32'(m_fill));
    chk("busy",    32'(o_busy),    32'(e_busy));
    service();
  endtask

  task automatic tick_until_grant(input int max, input string tag);
    for (int i = 0; i < max; i++) begin
      tick();
      if (e_wren) return;
    end
    chk(tag, 32'd0, 32'd1);
  endtask

  task automatic run_until_done(input int r, input int max);
    for (int i = 0; i < max && left[r] > 0; i++) tick();
    chk("writes_done", 32'(left[r]), 32'd0);
  endtask

  task automatic wait_swap(input int max);
    for (int i = 0; i < max; i++) begin
      tick();
      if (o_swap === 1'b1) return;
    end
  endtask

  // Asynchronous reset a couple of time units into the current cycle.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_gnt",     32'(o_gnt),     32'd0);
    chk("rst_wr_en",   32'(o_wr_en),   32'd0);
    chk("rst_wr_addr", 32'(o_wr_addr), 32'd0);
    chk("rst_wr_data", 32'(o_wr_data), 32'd0);
    chk("rst_swap",    32'(o_swap),    32'd0);
    chk("rst_short",   32'(o_short),   32'd0);
    chk("rst_fill",    32'(o_fill),    32'd0);
    chk("rst_busy",    32'(o_busy),    32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    int order[$];
    int stamp[$];
    int g;

    clear_requests();
    model_reset();
    do_reset();

    // Single write from requester 0 into bank 1 (serializer reads bank 0).
    request(0, 1);
    addr[0 +: AW] = 11'd5;
    data[0 +: DW] = 12'hABC;
    tick_until_grant(4, "single_timeout");
    chk("single_gnt",  32'(o_gnt),     32'h1);
    chk("single_addr", 32'(o_wr_addr), 32'h805);
    chk("single_data", 32'(o_wr_data), 32'hABC);
    tick();
    chk("single_fill", 32'(o_fill), 32'd1);

    // All requesters held: strict rotation starting from a reset pointer.
    do_reset();
    for (int r = 0; r < NREQ; r++) request(r, 1000);
    for (int i = 0; i < 14; i++) begin
      tick();
      g = onehot_idx(o_gnt);
      if (g >= 0) begin
        order.push_back(g);
        stamp.push_back(cycle);
      end
    end
    clear_requests();
    chk("rr_count", 32'(order.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < order.size(); i++) chk("rr_order", 32'(order[i]), 32'(i % NREQ));
    for (int i = 1; i < 6 && i < stamp.size(); i++) chk("rr_spacing", 32'(stamp[i] - stamp[i-1]), 32'd2);

    // Exactly one bank's worth of writes, then a swap.
    do_reset();
    request(1, BW);
    run_until_done(1, 2 * BW + 10);
    tick();
    chk("full_fill", 32'(o_fill), 32'd2048);
    sw = 1'b1;
    wait_swap(4);
    chk("full_swap",  32'(o_swap),  32'd1);
    chk("full_short", 32'(o_short), 32'd0);
    chk("full_clear", 32'(o_fill),  32'd0);
    request(1, 1);
    tick_until_grant(6, "post_swap_timeout");
    chk("post_swap_bank", 32'(o_wr_addr[AW]), 32'd0);
    tick();

    // One write past full saturates; a partially filled bank reports short.
    sw = 1'b0;
    do_reset();
    request(2, BW + 1);
    run_until_done(2, 2 * BW + 12);
    tick();
    chk("sat_fill", 32'(o_fill), 32'd2048);
    sw = 1'b1;
    wait_swap(4);
    chk("sat_swap",  32'(o_swap),  32'd1);
    chk("sat_short", 32'(o_short), 32'd0);
    request(2, 100);
    run_until_done(2, 220);
    tick();
    chk("part_fill", 32'(o_fill), 32'd100);
    sw = 1'b0;
    wait_swap(4);
    chk("part_swap",  32'(o_swap),  32'd1);
    chk("part_short", 32'(o_short), 32'd1);

    // Swap arriving while a write is in flight.
    do_reset();
    request(0, 1000);
    tick_until_grant(4, "inflight_timeout");
    chk("inflight_bank", 32'(o_wr_addr[AW]), 32'd1);
    sw = 1'b1;
    tick();
    chk("inflight_fill", 32'(o_fill), 32'd1);
    tick();
    chk("inflight_swap",  32'(o_swap),  32'd1);
    chk("inflight_nognt", 32'(o_gnt),   32'd0);
    chk("inflight_short", 32'(o_short), 32'd1);
    tick();
    chk("inflight_next_gnt",  32'(o_gnt),          32'd1);
    chk("inflight_next_bank", 32'(o_wr_addr[AW]),  32'd0);
    tick();
    clear_requests();

    // Reset in the middle of a write; pointer restarts at requester 0.
    sw = 1'b0;
    do_reset();
    request(0, 1000);
    request(2, 1000);
    tick_until_grant(4, "abort_first_timeout");
    chk("abort_first", 32'(o_gnt), 32'h1);
    tick_until_grant(4, "abort_second_timeout");
    chk("abort_second", 32'(o_gnt),   32'h4);
    chk("abort_wr_en",  32'(o_wr_en), 32'd1);
    do_reset();
    tick_until_grant(4, "regrant_timeout");
    chk("regrant_ptr0", 32'(o_gnt), 32'h1);
    tick();
    clear_requests();

    // Randomized traffic and serializer swaps against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int r = 0; r < NREQ; r++)
        if (((req >> r) & 3'b1) == 0 && $urandom_range(3) == 0) request(r, 1);
      if ($urandom_range(39) == 0) sw = ~sw;
      tick();
    end
    clear_requests();
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
